// File: rtl/contrast_pkg.sv
// Shared constants and helpers for the contrast pipeline.
// Latency: n/a (package only).
// Backpressure: n/a.
package contrast_pkg;

    localparam int DW_DEF    = 8;
    localparam int NCH_DEF   = 3;
    localparam int LW_DEF    = 4;
    localparam int FRAC_DEF  = 3;
    localparam int UNITY_LVL = 1 << FRAC_DEF;

    // Clamp a signed value into the unsigned range [0, 2^w-1].
    function automatic logic [31:0] clamp_u(input logic signed [31:0] v, input int unsigned w);
        logic signed [31:0] hi;
        hi = (32'sd1 <<< w) - 32'sd1;
        if (v < 32'sd0)
            return '0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/contrast_chan.sv
// One colour channel: scale (pix - pivot) by level/2^FRAC, add pivot back, clamp.
// Latency: 2 clocks (S1 multiply, S2 shift/add/clamp), output registered.
// Backpressure: none; a new sample is accepted every clock.
module contrast_chan
    import contrast_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int LW   = LW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] pix,
    input  logic [DW-1:0] pivot,
    input  logic [LW-1:0] level,
`ifdef CONTRAST_CLIP_CNT_EN
    output logic          clip,
`endif
    output logic [DW-1:0] y
);

    localparam int PW = DW + LW + 1;
    localparam int SW = PW + 1;

    logic signed [DW:0]    d;
    logic signed [PW-1:0]  d_x, l_x, p_n, p_s1;
    logic        [DW-1:0]  pivot_s1;
    logic signed [SW-1:0]  s, sum;
    logic        [31:0]    cl;
    logic        [DW-1:0]  y_n;

    always_comb begin
        d   = $signed({1'b0, pix}) - $signed({1'b0, pivot});
        d_x = PW'(d);
        l_x = $signed({{(DW + 1){1'b0}}, level});
        p_n = d_x * l_x;
    end

    // Arithmetic shift floors toward -inf, so negative deltas round down.
    always_comb begin
        s   = SW'(p_s1) >>> FRAC;
        sum = $signed({{(SW - DW){1'b0}}, pivot_s1}) + s;
        cl  = clamp_u(32'(sum), DW);
        y_n = cl[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_s1     <= '0;
            pivot_s1 <= '0;
            y        <= '0;
        end else begin
            p_s1     <= p_n;
            pivot_s1 <= pivot;
            y        <= y_n;
        end
    end

`ifdef CONTRAST_CLIP_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip <= 1'b0;
        else
            clip <= (32'(sum) != cl);
    end
`endif

endmodule

// File: rtl/contrast_pipe.sv
// Per-pixel contrast about a pivot, frame-synchronous gain commit; CONTRAST_CLIP_CNT_EN adds clip_count.
// Latency: fixed 2 clocks for out_valid, out_pix and pass_thru.
// Backpressure: none; invalid pixels still advance through the pipeline.
module contrast_pipe
    import contrast_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int NCH     = NCH_DEF,
    parameter int LW      = LW_DEF,
    parameter int FRAC    = FRAC_DEF,
    parameter int LVL_RST = UNITY_LVL,
    parameter int PASS_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              frame_en,
    input  logic              inc,
    input  logic              dec,
    input  logic              in_valid,
    input  logic [NCH*DW-1:0] in_pix,
    input  logic [DW-1:0]     pivot,
    input  logic [PASS_W-1:0] pass_in,
    output logic              out_valid,
    output logic [NCH*DW-1:0] out_pix,
    output logic [PASS_W-1:0] pass_thru,
`ifdef CONTRAST_CLIP_CNT_EN
    output logic [15:0]       clip_count,
`endif
    output logic [LW-1:0]     level_out,
    output logic [LW-1:0]     level_pend
);

    logic          inc_q, dec_q, inc_p, dec_p;
    logic [LW-1:0] pend_n;

    always_comb begin
        inc_p  = inc & ~inc_q;
        dec_p  = dec & ~dec_q;
        pend_n = level_pend;
        if (inc_p && !dec_p && level_pend != '1)
            pend_n = level_pend + LW'(1);
        else if (dec_p && !inc_p && level_pend != '0)
            pend_n = level_pend - LW'(1);
    end

    // Commit uses pend_n so a step landing on the frame_en cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            level_pend <= LW'(LVL_RST);
            level_out  <= LW'(LVL_RST);
        end else begin
            inc_q      <= inc;
            dec_q      <= dec;
            level_pend <= pend_n;
            if (frame_en)
                level_out <= pend_n;
        end
    end

    logic              vld_s1, en_s1, en_s2;
    logic [NCH*DW-1:0] pix_s1, pix_s2, y_all;
    logic [PASS_W-1:0] pass_s1;
    logic [NCH-1:0]    clip_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_s1    <= 1'b0;
            out_valid <= 1'b0;
            en_s1     <= 1'b0;
            en_s2     <= 1'b0;
            pix_s1    <= '0;
            pix_s2    <= '0;
            pass_s1   <= '0;
            pass_thru <= '0;
        end else begin
            vld_s1    <= in_valid;
            out_valid <= vld_s1;
            en_s1     <= enable;
            en_s2     <= en_s1;
            pix_s1    <= in_pix;
            pix_s2    <= pix_s1;
            pass_s1   <= pass_in;
            pass_thru <= pass_s1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        contrast_chan #(.DW(DW), .LW(LW), .FRAC(FRAC)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .pix   (in_pix[i*DW +: DW]),
            .pivot (pivot),
            .level (level_out),
`ifdef CONTRAST_CLIP_CNT_EN
            .clip  (clip_v[i]),
`endif
            .y     (y_all[i*DW +: DW])
        );
    end

    // Both mux inputs are registers, so out_pix is glitch-free and bit-exact in bypass.
    assign out_pix = en_s2 ? y_all : pix_s2;

`ifdef CONTRAST_CLIP_CNT_EN
    logic [15:0] cnt_q, add, cnt_n;
    logic [16:0] sum17;

    always_comb begin
        add = '0;
        if (out_valid && en_s2)
            for (int i = 0; i < NCH; i++)
                add = add + 16'(clip_v[i]);
        sum17 = {1'b0, cnt_q} + {1'b0, add};
        cnt_n = sum17[16] ? 16'hFFFF : sum17[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            clip_count <= '0;
        end else if (frame_en) begin
            clip_count <= cnt_n;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_n;
        end
    end
`else
    assign clip_v = '0;
    logic unused_clip;
    assign unused_clip = ^clip_v;
`endif

endmodule

// File: tb/tb_contrast_pipe.sv
// Scoreboard bench for contrast_pipe: expected pixels queued at drive time, checked at output.
module tb_contrast_pipe;

    logic        clk = 1'b0;
    logic        rst_n, enable, frame_en, inc, dec, in_valid;
    logic [23:0] in_pix, out_pix, pass_in, pass_thru;
    logic [7:0]  pivot;
    logic        out_valid;
    logic [3:0]  level_out, level_pend;
`ifdef CONTRAST_CLIP_CNT_EN
    logic [15:0] clip_count;
`endif

    contrast_pipe dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .frame_en   (frame_en),
        .inc        (inc),
        .dec        (dec),
        .in_valid   (in_valid),
        .in_pix     (in_pix),
        .pivot      (pivot),
        .pass_in    (pass_in),
        .out_valid  (out_valid),
        .out_pix    (out_pix),
        .pass_thru  (pass_thru),
`ifdef CONTRAST_CLIP_CNT_EN
        .clip_count (clip_count),
`endif
        .level_out  (level_out),
        .level_pend (level_pend)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] pix;
        logic [23:0] pass;
        int          cyc;
    } sb_t;

    sb_t  sb[$];
    int   cycle = 0;
    int   n_chk = 0;
    int   n_err = 0;
    int   exp_lvl = 8;
    logic [7:0] pivot_nxt = 8'h80;
    logic       en_nxt = 1'b1;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] px, input logic [7:0] pv,
                                          input int lv, input bit en);
        logic [23:0] r;
        int d, p, s, y;
        if (!en) return px;
        r = '0;
        for (int ch = 0; ch < 3; ch++) begin
            d = int'(px[ch*8 +: 8]) - int'(pv);
            p = d * lv;
            s = p >>> 3;
            y = int'(pv) + s;
            if (y < 0) y = 0;
            if (y > 255) y = 255;
            r[ch*8 +: 8] = y[7:0];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                sb_t e;
                e = sb.pop_front();
                check("pix", 32'(out_pix), 32'(e.pix));
                check("pass", 32'(pass_thru), 32'(e.pass));
                check("latency", 32'(cycle - e.cyc), 32'd2);
            end
        end
    end

    task automatic drive(input bit v, input logic [23:0] px, input bit i_inc, input bit i_dec, input bit fe);
        @(posedge clk);
        #1;
        in_valid = v;
        in_pix   = px;
        inc      = i_inc;
        dec      = i_dec;
        frame_en = fe;
        pivot    = pivot_nxt;
        enable   = en_nxt;
        pass_in  = 24'($urandom);
    endtask

    task automatic push(input logic [23:0] e);
        sb_t s;
        s.pix  = e;
        s.pass = pass_in;
        s.cyc  = cycle;
        sb.push_back(s);
    endtask

    task automatic send(input logic [23:0] px);
        drive(1'b1, px, 1'b0, 1'b0, 1'b0);
        push(model(px, pivot_nxt, exp_lvl, en_nxt));
    endtask

    task automatic sendx(input logic [23:0] px, input logic [23:0] e);
        drive(1'b1, px, 1'b0, 1'b0, 1'b0);
        push(e);
    endtask

    task automatic idle(input bit i_inc, input bit i_dec, input bit fe);
        drive(1'b0, 24'h0, i_inc, i_dec, fe);
    endtask

    task automatic check_lvl(input string tag, input int act_exp, input int pend_exp);
        check({tag, "_act"}, 32'(level_out), 32'(act_exp));
        check({tag, "_pend"}, 32'(level_pend), 32'(pend_exp));
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; frame_en = 1'b0; inc = 1'b0; dec = 1'b0;
        in_valid = 1'b0; in_pix = '0; pivot = 8'h80; pass_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pix", 32'(out_pix), 32'd0);
        check("rst_pass", 32'(pass_thru), 32'd0);
        check_lvl("rst", 8, 8);
`ifdef CONTRAST_CLIP_CNT_EN
        check("rst_clip", 32'(clip_count), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Unity gain passes pixels through unchanged.
        sendx({8'h20, 8'h80, 8'hE0}, {8'h20, 8'h80, 8'hE0});
        repeat (3) send(24'($urandom));
        idle(0, 0, 0);
        check_lvl("unity", 8, 8);

        // Held inc gives one step; commit only on frame_en.
        idle(1, 0, 0);
        idle(1, 0, 0);
        check_lvl("inc_edge", 8, 9);
        repeat (8) idle(1, 0, 0);
        idle(0, 0, 0);
        check_lvl("inc_held", 8, 9);
        idle(0, 0, 1);
        idle(0, 0, 0);
        check_lvl("commit9", 9, 9);
        exp_lvl = 9;
        sendx({8'h20, 8'h80, 8'hE0}, {8'h14, 8'h80, 8'hEC});
        repeat (3) send(24'($urandom));

        // Saturate at the top level.
        repeat (12) begin
            idle(1, 0, 0);
            idle(0, 0, 0);
        end
        check_lvl("sat_pend", 9, 15);
        idle(0, 0, 1);
        idle(0, 0, 0);
        check_lvl("commit15", 15, 15);
        exp_lvl = 15;
        sendx({8'hFF, 8'h00, 8'h81}, {8'hFF, 8'h00, 8'h81});
        repeat (3) send(24'($urandom));

        // Saturate at zero: every output is the pivot.
        repeat (20) begin
            idle(0, 1, 0);
            idle(0, 0, 0);
        end
        idle(0, 0, 1);
        idle(0, 0, 0);
        check_lvl("commit0", 0, 0);
        exp_lvl = 0;
        sendx(24'($urandom), 24'h808080);
        pivot_nxt = 8'h40;
        sendx(24'($urandom), 24'h404040);
        sendx(24'hFF0012, 24'h404040);

        // Simultaneous inc/dec with frame_en: no change. Lone inc with frame_en: committed.
        idle(1, 1, 1);
        idle(0, 0, 0);
        check_lvl("incdec", 0, 0);
        idle(1, 0, 1);
        idle(0, 0, 0);
        check_lvl("inc_fe", 1, 1);
        exp_lvl = 1;
        pivot_nxt = 8'h80;
        repeat (4) send(24'($urandom));

        // Bypass: pixels unmodified, level logic keeps running.
        en_nxt = 1'b0;
        repeat (4) send(24'($urandom));
        idle(1, 0, 0);
        idle(0, 0, 0);
        check_lvl("bypass_lvl", 1, 2);
        en_nxt = 1'b1;
        idle(0, 0, 1);
        exp_lvl = 2;

        // Mixed valid/idle stream with changing pivot.
        for (int i = 0; i < 24; i++) begin
            pivot_nxt = 8'($urandom);
            if ($urandom_range(1, 0) == 1) send(24'($urandom));
            else idle(0, 0, 0);
        end
        pivot_nxt = 8'h80;

        // Reset mid-stream flushes the pipe asynchronously.
        send(24'($urandom));
        send(24'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_pix", 32'(out_pix), 32'd0);
        check_lvl("midrst", 8, 8);
        sb.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_lvl = 8;
        send(24'($urandom));
        send(24'($urandom));

`ifdef CONTRAST_CLIP_CNT_EN
        repeat (7) begin
            idle(1, 0, 0);
            idle(0, 0, 0);
        end
        idle(0, 0, 1);
        idle(0, 0, 0);
        check_lvl("clip_lvl", 15, 15);
        exp_lvl = 15;
        repeat (4) sendx({8'hFF, 8'h00, 8'h80}, {8'hFF, 8'h00, 8'h80});
        repeat (3) idle(0, 0, 0);
        idle(0, 0, 1);
        idle(0, 0, 0);
        check("clip_cnt8", 32'(clip_count), 32'd8);
        idle(0, 0, 1);
        idle(0, 0, 0);
        check("clip_clear", 32'(clip_count), 32'd0);
        en_nxt = 1'b0;
        repeat (4) send({8'hFF, 8'h00, 8'h80});
        repeat (3) idle(0, 0, 0);
        idle(0, 0, 1);
        idle(0, 0, 0);
        check("clip_bypass", 32'(clip_count), 32'd0);
        en_nxt = 1'b1;
`endif

        idle(0, 0, 0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        #1;
        check("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
